// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder/scan sequencer: mode encoding
// and a constant-foldable ceiling log2 used to size counters.
package decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Smallest r such that 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// Control/status bundle between a controller and decoder_seq.
interface decoder_seq_if #(
    parameter int unsigned SEL_W = 2
) ();
    import decoder_pkg::*;

    localparam int unsigned OUT_W = 1 << SEL_W;

    logic             en;
    mode_e            mode;
    logic             load;
    logic [SEL_W-1:0] s;
    logic [OUT_W-1:0] o;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, load, s,
        input  o, idx, wrap
    );

    modport slave (
        input  en, mode, load, s,
        output o, idx, wrap
    );

endinterface

// File: rtl/decoder_seq_onehot_dec.sv
// Purely combinational binary-to-one-hot decode.
module onehot_dec #(
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0]        sel_i,
    output logic [(1 << SEL_W)-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with a dwell-timed scan sequencer.
// All state (index, dwell counter, output, wrap flag) lives here.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 1
) (
    input  logic          clk,
    input  logic          rst,
    decoder_seq_if.slave  bus
);

    localparam int unsigned OUT_W    = 1 << SEL_W;
    localparam int unsigned CNT_W    = clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] o_q, o_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] onehot_next;

    // Decode the index being written this edge so o and idx stay aligned.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .sel_i    (idx_d),
        .onehot_o (onehot_next)
    );

    // Next-state: direct load or dwell-timed advance; counter parks at 0 outside scan.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;

        if (bus.mode == MODE_DIRECT) begin
            cnt_d = '0;
            if (bus.en && bus.load) begin
                idx_d = bus.s;
            end
        end else if (bus.en) begin
            if (cnt_q == DWELL_M1) begin
                cnt_d  = '0;
                idx_d  = idx_q + SEL_W'(1);
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        o_d = bus.en ? onehot_next : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            o_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.o    = o_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: a SEL_W=2/DWELL=3 instance for direct,
// gating, scan, freeze and reset behaviour, and a SEL_W=4/DWELL=1 sweep.
module tb_decoder_seq;
    import decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic mon_on;

    decoder_seq_if #(.SEL_W(2)) a_if ();
    decoder_seq_if #(.SEL_W(4)) b_if ();

    decoder_seq #(.SEL_W(2), .DWELL(3)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    decoder_seq #(.SEL_W(4), .DWELL(1)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] o, input logic [1:0] idx, input logic w);
        check({tag, ".o"},    32'(a_if.o),    32'(o));
        check({tag, ".idx"},  32'(a_if.idx),  32'(idx));
        check({tag, ".wrap"}, 32'(a_if.wrap), 32'(w));
    endtask

    task automatic chk_b(input string tag, input logic [15:0] o, input logic [3:0] idx, input logic w);
        check({tag, ".o"},    32'(b_if.o),    32'(o));
        check({tag, ".idx"},  32'(b_if.idx),  32'(idx));
        check({tag, ".wrap"}, 32'(b_if.wrap), 32'(w));
    endtask

    // Output must never be multi-hot, on either instance, in any cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            check("a_onehot0", 32'($countones(a_if.o) <= 1), 32'(1));
            check("b_onehot0", 32'($countones(b_if.o) <= 1), 32'(1));
        end
    end

    initial begin
        int unsigned e;
        logic [15:0] seen;

        mon_on    = 1'b0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        a_if.en   = 1'b0;
        a_if.mode = MODE_DIRECT;
        a_if.load = 1'b0;
        a_if.s    = '0;
        b_if.en   = 1'b0;
        b_if.mode = MODE_DIRECT;
        b_if.load = 1'b0;
        b_if.s    = '0;

        tick();
        mon_on = 1'b1;
        chk_a("a_reset", 4'b0000, 2'd0, 1'b0);

        // Direct loads
        rst_a     = 1'b0;
        a_if.en   = 1'b1;
        a_if.load = 1'b1;
        a_if.s    = 2'd2;
        tick();
        chk_a("a_load2", 4'b0100, 2'd2, 1'b0);
        a_if.s = 2'd3;
        tick();
        chk_a("a_load3", 4'b1000, 2'd3, 1'b0);

        // en gating in direct mode; load ignored while disabled
        a_if.en = 1'b0;
        a_if.s  = 2'd1;
        tick();
        chk_a("a_en_off", 4'b0000, 2'd3, 1'b0);
        a_if.load = 1'b0;
        a_if.en   = 1'b1;
        tick();
        chk_a("a_en_on", 4'b1000, 2'd3, 1'b0);

        // Direct load of 0 must not pulse wrap
        a_if.load = 1'b1;
        a_if.s    = 2'd0;
        tick();
        chk_a("a_load0", 4'b0001, 2'd0, 1'b0);

        // Scan from idx 0, DWELL=3: wrap only when idx returns to 0 at edge 12
        a_if.load = 1'b0;
        a_if.mode = MODE_SCAN;
        for (int k = 1; k <= 15; k++) begin
            tick();
            e = (32'(k) / 3) % 4;
            chk_a($sformatf("a_scan%0d", k), 4'(1 << e), 2'(e), k == 12);
        end

        // Freeze one cycle into idx 1, then resume: two more cycles at idx 1
        a_if.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_a($sformatf("a_frz%0d", k), 4'b0000, 2'd1, 1'b0);
        end
        a_if.en = 1'b1;
        tick();
        chk_a("a_res0", 4'b0010, 2'd1, 1'b0);
        tick();
        chk_a("a_res1", 4'b0010, 2'd1, 1'b0);
        tick();
        chk_a("a_res2", 4'b0100, 2'd2, 1'b0);

        // load ignored while scanning
        a_if.load = 1'b1;
        a_if.s    = 2'd0;
        tick();
        chk_a("a_scan_load", 4'b0100, 2'd2, 1'b0);
        a_if.load = 1'b0;

        // Mid-scan reset, then release with en=1
        rst_a = 1'b1;
        tick();
        chk_a("a_midrst", 4'b0000, 2'd0, 1'b0);
        rst_a = 1'b0;
        tick();
        chk_a("a_release", 4'b0001, 2'd0, 1'b0);

        // Wide instance: reset, load 0, then DWELL=1 sweep
        chk_b("b_reset", 16'h0000, 4'd0, 1'b0);
        rst_b     = 1'b0;
        b_if.en   = 1'b1;
        b_if.load = 1'b1;
        b_if.s    = 4'd0;
        tick();
        chk_b("b_load0", 16'h0001, 4'd0, 1'b0);
        b_if.load = 1'b0;
        b_if.mode = MODE_SCAN;
        seen = 16'h0001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = 32'(k) % 16;
            chk_b($sformatf("b_sweep%0d", k), 16'(1 << e), 4'(e), k == 16);
            if (k < 16) begin
                seen = seen | b_if.o;
            end
        end
        check("b_all_seen", 32'(seen), 32'h0000_FFFF);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it decodes a loaded select value. In scan mode it walks the one-hot output through every position, holding each for a programmable dwell time. It sits between control logic and banks of enables, row strobes or channel selects, and replaces purely combinational 2-to-4 decoding wherever outputs must be glitch-free, registered and optionally auto-sequenced.

## Interface
- SEL_W, 2, select width; OUT_W = 2**SEL_W is a derived localparam, not overridable
- DWELL, 1, clock cycles each position is held in scan mode; legal range 1..65535
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  output enable; 0 forces o to all zeros and freezes scan
- mode  in  1  0 = direct, 1 = scan
- load  in  1  direct mode: capture s on this edge
- s  in  SEL_W  select value
- o  out  OUT_W  registered one-hot output; bit k asserted when idx == k and en was 1
- idx  out  SEL_W  current position index
- wrap  out  1  one-cycle pulse when scan advances from OUT_W-1 to 0

## Operation
- Reset (rst=1 at an edge) sets:
  - idx = 0
  - o = 0
  - wrap = 0
  - dwell counter = 0
- rst has priority over every other input, including mid-scan.
- Output register: each edge, o <= en ? onehot(idx_next) : 0, where idx_next is the value idx takes on that same edge. o is never multi-hot. o is all-zero only during reset or when en=0.
- Direct mode (mode=0):
  - load=1 and en=1: idx <= s.
  - load=0: idx holds.
  - Dwell counter is held at 0. wrap stays 0.
  - load is ignored when en=0; idx holds.
- Scan mode (mode=1), en=1:
  - Dwell counter counts 0..DWELL-1.
  - On the edge where the counter equals DWELL-1, the counter clears and idx <= idx+1 modulo OUT_W.
  - On the same edge, wrap <= 1 if idx was OUT_W-1; otherwise wrap <= 0.
  - load is ignored.
- Scan mode, en=0: counter and idx hold, wrap <= 0, o <= 0. Restoring en resumes from the held counter value.
- Mode change:
  - Entering scan: the counter restarts at 0 and idx continues from its current value.
  - Leaving scan: the counter clears and idx holds.
- DWELL=1: idx advances every enabled cycle.

## Timing
- Direct-mode latency is 1 cycle: load sampled at edge n; idx and o are valid after edge n.
- Scan: each index is presented on o for exactly DWELL cycles while en=1. One full sweep takes OUT_W*DWELL cycles.
- wrap is registered. It is high in the first cycle idx reads 0 after a sweep, and only then. It never asserts on reset or on a direct load of 0.
- en changes affect o at the next edge; there is no combinational path from en to o.
- Releasing rst with en=1: o = onehot(0) after the first non-reset edge.

## Structure
- Shared package decoder_pkg:
  - MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1
  - function clog2, used to size the dwell counter as clog2(DWELL+1) bits
- Sub-module onehot_dec (param SEL_W): purely combinational binary-to-one-hot decode, instantiated once on idx_next. All state lives in decoder_seq.

## Test plan
- Reset/direct, SEL_W=2: rst 1 cycle, en=1, load s=2 → o=0100, idx=2 one cycle after load. Load s=3 → o=1000. No wrap.
- en gating: en=0 while idx=3 → o=0000 next cycle, idx stays 3. en=1 → o=1000.
- Scan, DWELL=3, SEL_W=2, start idx=0: o steps 0001,0010,0100,1000,0001, holding each for 3 cycles. wrap is high exactly on the cycle o returns to 0001 (cycle 12).
- Scan freeze: en=0 after 1 cycle of dwell at idx=1, hold 5 cycles, en=1 → idx=1 stays for exactly 2 more cycles.
- Mid-scan reset and ignored load: load s=0 while scanning at idx=2 → no effect. rst at idx=2 → idx=0, o=0, wrap=0 next cycle.
- Width sweep: SEL_W=4, DWELL=1 → 16 consecutive distinct one-hot values, then a wrap pulse. No multi-hot output observed in any cycle; this is checked by assertion throughout.
